// File: rtl/highway_light_ctrl_if.sv
// Signal bundle between the highway controller and its environment (country side,
// vehicle sensor and timing configuration).
interface highway_light_ctrl_if;
  logic       sensor_c;
  logic [2:0] out_c;
  logic [6:0] min_green;
  logic [3:0] yellow_time;
  logic [2:0] out_h;
  logic       req_pending;

  modport master (
    output sensor_c, out_c, min_green, yellow_time,
    input  out_h, req_pending
  );

  modport slave (
    input  sensor_c, out_c, min_green, yellow_time,
    output out_h, req_pending
  );
endinterface

// File: rtl/highway_light_ctrl.sv
// Highway-side light controller: green by default, yields to the country road on a
// sensor request, and only returns to green after an all-red clearance.
module highway_light_ctrl #(
  parameter int ALLRED_CYC = 2,
  parameter int WAIT_MAX   = 15
) (
  input logic             clk,
  input logic             reset_n,
  highway_light_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    GREEN  = 3'd0,
    YELLOW = 3'd1,
    RED    = 3'd2,
    SERVE  = 3'd3,
    ALLRED = 3'd4
  } state_t;

  localparam logic [6:0] ALLRED_LIM = 7'(ALLRED_CYC);
  localparam logic [6:0] WAIT_LIM   = 7'(WAIT_MAX);
  localparam logic [2:0] LIGHT_RED  = 3'b100;

  state_t     state_q, state_d;
  logic [6:0] count_q, count_d;
  logic       req_q, req_d;
  logic       country_red;

  // Anything other than an exact red code from the country side counts as "not red".
  assign country_red = (bus.out_c == LIGHT_RED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= GREEN;
      count_q <= 7'd0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    req_d   = req_q;

    case (state_q)
      GREEN: begin
        if (bus.sensor_c) req_d = 1'b1;
        if ((req_q || bus.sensor_c) && (count_q >= bus.min_green)) begin
          state_d = YELLOW;
          count_d = 7'd0;
        end else if (count_q < bus.min_green) begin
          count_d = count_q + 7'd1;
        end
      end

      YELLOW: begin
        if (bus.sensor_c) req_d = 1'b1;
        if (count_q < {3'b000, bus.yellow_time}) begin
          count_d = count_q + 7'd1;
        end else begin
          state_d = RED;
          count_d = 7'd0;
        end
      end

      // Give up on the request if the country side never leaves red.
      RED: begin
        if (!country_red) begin
          state_d = SERVE;
          count_d = 7'd0;
        end else if (count_q >= WAIT_LIM) begin
          state_d = ALLRED;
          count_d = 7'd0;
          req_d   = 1'b0;
        end else begin
          count_d = count_q + 7'd1;
        end
      end

      SERVE: begin
        if (country_red) begin
          state_d = ALLRED;
          count_d = 7'd0;
          req_d   = 1'b0;
        end
      end

      ALLRED: begin
        if (count_q < ALLRED_LIM) begin
          count_d = count_q + 7'd1;
        end else begin
          state_d = GREEN;
          count_d = 7'd0;
        end
      end

      // An illegal encoding recovers through all-red so the highway never jumps to green.
      default: begin
        state_d = ALLRED;
        count_d = 7'd0;
        req_d   = 1'b0;
      end
    endcase
  end

  assign bus.out_h       = (state_q == GREEN)  ? 3'b001 :
                           (state_q == YELLOW) ? 3'b010 : LIGHT_RED;
  assign bus.req_pending = req_q;

endmodule

// File: tb/tb_highway_light_ctrl.sv
// Directed scoreboard checks of the highway controller's phase timing and reset,
// followed by a randomised run against a cooperating country-side model.
module tb_highway_light_ctrl;

  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b100;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   failures;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  highway_light_ctrl_if hl_if ();

  highway_light_ctrl #(.ALLRED_CYC(2), .WAIT_MAX(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (hl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic s, input logic [2:0] oc,
                                input logic [2:0] eh, input logic er, input string tag);
    hl_if.sensor_c = s;
    hl_if.out_c    = oc;
    exp_q.push_back({eh, er});
    tag_q.push_back(tag);
  endtask

  task automatic check_output();
    logic [3:0] expv;
    string      tag;
    tests_run++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: observed out_h=%b req=%b expected an entry",
               hl_if.out_h, hl_if.req_pending);
    end else begin
      expv = exp_q.pop_front();
      tag  = tag_q.pop_front();
      assert ({hl_if.out_h, hl_if.req_pending} === expv) else begin
        failures++;
        $error("[TB] FAIL %s: observed out_h=%b req=%b expected out_h=%b req=%b",
               tag, hl_if.out_h, hl_if.req_pending, expv[3:1], expv[0]);
      end
    end
  endtask

  // One clock: drive inputs, let the edge consume them, then compare the result.
  task automatic tick(input logic s, input logic [2:0] oc,
                      input logic [2:0] eh, input logic er, input string tag);
    apply_stimulus(s, oc, eh, er, tag);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic ticks(input int n, input logic s, input logic [2:0] oc,
                       input logic [2:0] eh, input logic er, input string tag);
    for (int i = 0; i < n; i++) tick(s, oc, eh, er, tag);
  endtask

  // Reset lands between clock edges; outputs must respond before the next edge.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    apply_stimulus(1'b0, LR, LG, 1'b0, tag);
    check_output();
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [2:0] c_light;
    int         c_cnt;
    logic       armed;
    logic       s;

    tests_run = 0;
    failures  = 0;
    reset_n   = 1'b0;
    hl_if.sensor_c    = 1'b0;
    hl_if.out_c       = LR;
    hl_if.min_green   = 7'd5;
    hl_if.yellow_time = 4'd3;

    #1;
    apply_stimulus(1'b0, LR, LG, 1'b0, "reset_state");
    check_output();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    ticks(100, 1'b0, LR, LG, 1'b0, "idle_green");

    async_reset("reset_before_req");
    ticks(2, 1'b0, LR, LG, 1'b0, "green_count");
    tick(1'b1, LR, LG, 1'b1, "req_latched");
    ticks(2, 1'b0, LR, LG, 1'b1, "green_min_hold");
    ticks(4, 1'b0, LR, LY, 1'b1, "yellow_4cyc");
    tick(1'b0, LR, LR, 1'b1, "red_entry");

    ticks(10, 1'b1, LG, LR, 1'b1, "serve_country_green");
    ticks(3, 1'b0, LY, LR, 1'b1, "serve_country_yellow");
    tick(1'b0, LR, LR, 1'b0, "allred_entry_clears_req");
    ticks(2, 1'b1, LR, LR, 1'b0, "allred_ignores_sensor");
    tick(1'b1, LR, LG, 1'b0, "back_to_green");

    hl_if.yellow_time = 4'd0;
    tick(1'b1, LR, LG, 1'b1, "req2_latched");
    ticks(4, 1'b0, LR, LG, 1'b1, "req2_green_hold");
    tick(1'b0, LR, LY, 1'b1, "yellow_time0");
    tick(1'b0, LR, LR, 1'b1, "red_entry_timeout");
    ticks(15, 1'b1, LR, LR, 1'b1, "red_waiting");
    tick(1'b0, LR, LR, 1'b0, "red_abort");
    ticks(2, 1'b0, LR, LR, 1'b0, "abort_allred");
    tick(1'b0, LR, LG, 1'b0, "abort_back_green");

    hl_if.min_green = 7'd0;
    tick(1'b1, LR, LY, 1'b1, "min_green0");
    tick(1'b0, LR, LR, 1'b1, "red_after_short_yellow");
    ticks(2, 1'b0, LG, LR, 1'b1, "serve_before_reset");
    async_reset("reset_mid_serve");

    hl_if.yellow_time = 4'd3;
    tick(1'b1, LR, LY, 1'b1, "yellow_before_reset");
    tick(1'b0, LR, LY, 1'b1, "yellow_mid");
    async_reset("reset_mid_yellow");

    hl_if.min_green = 7'd20;
    ticks(2, 1'b1, LR, LG, 1'b1, "long_min_green");
    hl_if.min_green = 7'd2;
    tick(1'b0, LR, LY, 1'b1, "min_green_lowered");

    async_reset("reset_before_random");
    hl_if.min_green   = 7'($urandom_range(0, 6));
    hl_if.yellow_time = 4'($urandom_range(0, 3));
    c_light = LR;
    c_cnt   = 0;
    armed   = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      s = ($urandom_range(0, 7) == 0);
      hl_if.sensor_c = s;
      hl_if.out_c    = c_light;
      @(posedge clk);
      #1;
      tests_run++;
      assert ($onehot(hl_if.out_h)) else begin
        failures++;
        $error("[TB] FAIL onehot_out_h: observed out_h=%b expected one-hot", hl_if.out_h);
      end
      tests_run++;
      assert ((hl_if.out_h === LR) || (hl_if.out_c === LR)) else begin
        failures++;
        $error("[TB] FAIL conflict: observed out_h=%b out_c=%b expected one side red",
               hl_if.out_h, hl_if.out_c);
      end
      // The country side only reacts on the first cycle the highway shows red.
      if (hl_if.out_h !== LR) begin
        armed = 1'b1;
      end else if (armed) begin
        armed = 1'b0;
        if ($urandom_range(0, 3) != 0) begin
          c_light = LG;
          c_cnt   = $urandom_range(1, 8);
        end
      end else if (c_light == LG) begin
        c_cnt--;
        if (c_cnt == 0) begin
          c_light = LY;
          c_cnt   = 2;
        end
      end else if (c_light == LY) begin
        c_cnt--;
        if (c_cnt == 0) c_light = LR;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
